// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder share arbiter.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = (n > 1) ? $clog2(n) : 1;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid after ptr (wrapping) wins.
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [ID_W-1:0]    idx_c,
    output logic               any_c
);
    logic [ID_W-1:0] cand;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        cand    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((32'(ptr) + off) % NUM_REQ);
            if (!any_c && valid[cand]) begin
                any_c         = 1'b1;
                idx_c         = cand;
                grant_c[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/carry_select_adder.sv
// Carry-select adder: low half ripples, high half is precomputed for both carries.
module carry_select_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum_c,
    output logic         cout_c
);
    localparam int unsigned LO   = N / 2;
    localparam int unsigned HI   = N - LO;
    localparam int unsigned LO_W = LO + 1;
    localparam int unsigned HI_W = HI + 1;

    logic [LO:0] lo_sum;
    logic [HI:0] hi_sum0;
    logic [HI:0] hi_sum1;

    assign lo_sum  = LO_W'(a[LO-1:0]) + LO_W'(b[LO-1:0]) + LO_W'(cin);
    assign hi_sum0 = HI_W'(a[N-1:LO]) + HI_W'(b[N-1:LO]);
    assign hi_sum1 = HI_W'(a[N-1:LO]) + HI_W'(b[N-1:LO]) + HI_W'(1'b1);

    assign {cout_c, sum_c} = lo_sum[LO] ? {hi_sum1, lo_sum[LO-1:0]}
                                        : {hi_sum0, lo_sum[LO-1:0]};
endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one carry_select_adder among NUM_REQ requesters with round-robin grant.
// Optional two's-complement overflow output enabled by ADDER_ARB_OVF_EN.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int unsigned N       = 8,
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_cin,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [N-1:0]         resp_sum,
    output logic                 resp_cout,
    output logic                 busy
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                 resp_ovf
`endif
);
    arb_state_t state, state_nxt;

    logic [N-1:0]       op_a, op_b;
    logic               op_cin;
    logic [ID_W-1:0]    op_id;
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic               win_any;
    logic               accept;
    logic [N-1:0]       sum_c;
    logic               cout_c;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid   (req_valid),
        .ptr     (ptr),
        .grant_c (grant),
        .idx_c   (win_idx),
        .any_c   (win_any)
    );

    carry_select_adder #(.N(N)) u_adder (
        .a      (op_a),
        .b      (op_b),
        .cin    (op_cin),
        .sum_c  (sum_c),
        .cout_c (cout_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; a new request is accepted from IDLE or on the response handshake.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_any) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    if (win_any) begin
                        accept    = 1'b1;
                        state_nxt = CALC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant is combinational so the requester sees it in the accept cycle; silenced in reset.
    assign req_ready = (accept && !rst) ? grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            op_cin     <= 1'b0;
            op_id      <= '0;
            ptr        <= ID_W'(NUM_REQ - 1);
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            resp_id    <= '0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
        end else begin
            resp_valid <= (state_nxt == RESP);
            busy       <= (state_nxt != IDLE);
            if (accept) begin
                op_a   <= req_a[32'(win_idx)*N +: N];
                op_b   <= req_b[32'(win_idx)*N +: N];
                op_cin <= req_cin[win_idx];
                op_id  <= win_idx;
                ptr    <= win_idx;
            end
            if (state == CALC) begin
                resp_id   <= op_id;
                resp_sum  <= sum_c;
                resp_cout <= cout_c;
            end
        end
    end

`ifdef ADDER_ARB_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                resp_ovf <= 1'b0;
        else if (state == CALC) resp_ovf <= (op_a[N-1] == op_b[N-1]) && (sum_c[N-1] != op_a[N-1]);
    end
`endif

endmodule
